// File: rtl/cond_source.sv
// rtl/cond_source.sv - clocked conditional source: forwards an input token (ctl_a) or injects one (ctl_b)
// Optional feature macro: COND_SOURCE_COUNT_EN (injected value is a wrapping counter seeded with SRC_VAL)
module cond_source #(
  parameter int N = 32,
  parameter logic [N-1:0] SRC_VAL = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_i,
  output logic         a_i,
  input  logic [N-1:0] d_i,
  input  logic         ctl_a,
  input  logic         ctl_b,
  output logic         actl_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] d_o,
  output logic         ctl_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RTZ = 2'd2} state_t;

  state_t       state_q, state_d;
  logic         path_b_q, path_b_d;
  logic         r_o_q, r_o_d;
  logic         a_i_q, a_i_d;
  logic         actl_q, actl_d;
  logic         err_q, err_d;
  logic [N-1:0] d_q, d_d;
  logic [N-1:0] inj_val;

`ifdef COND_SOURCE_COUNT_EN
  logic [N-1:0] cnt_q, cnt_d;
  assign inj_val = cnt_q;
`else
  assign inj_val = SRC_VAL;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      path_b_q <= 1'b0;
      r_o_q    <= 1'b0;
      a_i_q    <= 1'b0;
      actl_q   <= 1'b0;
      err_q    <= 1'b0;
      d_q      <= '0;
`ifdef COND_SOURCE_COUNT_EN
      cnt_q    <= SRC_VAL;
`endif
    end else begin
      state_q  <= state_d;
      path_b_q <= path_b_d;
      r_o_q    <= r_o_d;
      a_i_q    <= a_i_d;
      actl_q   <= actl_d;
      err_q    <= err_d;
      d_q      <= d_d;
`ifdef COND_SOURCE_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    path_b_d = path_b_q;
    r_o_d    = r_o_q;
    a_i_d    = a_i_q;
    actl_d   = actl_q;
    err_d    = err_q;
    d_d      = d_q;
`ifdef COND_SOURCE_COUNT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Both rails high is illegal regardless of r_i; no token may start.
        if (ctl_a && ctl_b) begin
          err_d = 1'b1;
        end else if (ctl_a && r_i) begin
          d_d      = d_i;
          path_b_d = 1'b0;
          r_o_d    = 1'b1;
          state_d  = REQ;
        end else if (ctl_b) begin
          d_d      = inj_val;
          path_b_d = 1'b1;
          r_o_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (a_o) begin
          r_o_d   = 1'b0;
          actl_d  = 1'b1;
          a_i_d   = !path_b_q;
          state_d = RTZ;
        end
      end
      RTZ: begin
        if (!a_o && !ctl_a && !ctl_b && (path_b_q || !r_i)) begin
          a_i_d   = 1'b0;
          actl_d  = 1'b0;
          state_d = IDLE;
`ifdef COND_SOURCE_COUNT_EN
          if (path_b_q) cnt_d = cnt_q + N'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign r_o     = r_o_q;
  assign a_i     = a_i_q;
  assign actl_i  = actl_q;
  assign ctl_err = err_q;
  assign d_o     = d_q;

endmodule

// File: tb/tb_cond_source.sv
// tb/tb_cond_source.sv - self-checking bench for cond_source (both COND_SOURCE_COUNT_EN builds)
module tb_cond_source;

`ifdef COND_SOURCE_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic r_i = 1'b0, ctl_a = 1'b0, ctl_b = 1'b0, a_o = 1'b0;
  logic [31:0] d_i = '0;
  logic a_i, actl_i, r_o, ctl_err;
  logic [31:0] d_o;

  logic w_r_i = 1'b0, w_ctl_a = 1'b0, w_ctl_b = 1'b0, w_a_o = 1'b0;
  logic [31:0] w_d_i = '0;
  logic w_a_i, w_actl_i, w_r_o, w_ctl_err;
  logic [31:0] w_d_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cond_source #(.N(32), .SRC_VAL(32'd5)) dut (
    .clk(clk), .rst(rst), .r_i(r_i), .a_i(a_i), .d_i(d_i), .ctl_a(ctl_a), .ctl_b(ctl_b),
    .actl_i(actl_i), .r_o(r_o), .a_o(a_o), .d_o(d_o), .ctl_err(ctl_err));

  cond_source #(.N(32), .SRC_VAL(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .rst(rst), .r_i(w_r_i), .a_i(w_a_i), .d_i(w_d_i), .ctl_a(w_ctl_a), .ctl_b(w_ctl_b),
    .actl_i(w_actl_i), .r_o(w_r_o), .a_o(w_a_o), .d_o(w_d_o), .ctl_err(w_ctl_err));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r_i = 0; ctl_a = 0; ctl_b = 0; a_o = 0; d_i = '0;
    w_ctl_b = 0; w_a_o = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0; step(); step(); rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    ctl_a = 1; ctl_b = 1; step();
    ctl_a = 0; ctl_b = 0; step();
    ctl_a = 1; r_i = 1; d_i = 32'h1357_9BDF; step();
    checks++; if (r_o !== 1'b1) begin errors++; $display("FAIL reset_pre_req r_o=%b want 1", r_o); end
    rst = 0; step();
    checks++; if ({r_o, a_i, actl_i, ctl_err} !== 4'b0000) begin errors++;
      $display("FAIL reset_outputs r_o,a_i,actl_i,ctl_err=%b want 0000", {r_o, a_i, actl_i, ctl_err}); end
    checks++; if (d_o !== 32'h0) begin errors++; $display("FAIL reset_d_o got %h want 0", d_o); end
    step(); clear_inputs(); rst = 1;
    ctl_b = 1; step();
    checks++; if (r_o !== 1'b1 || d_o !== 32'd5) begin errors++;
      $display("FAIL reset_idle_restart r_o=%b d_o=%h want 1/5", r_o, d_o); end
    do_reset();
  endtask

  task automatic test_pass();
    do_reset();
    ctl_a = 1; r_i = 1; d_i = 32'hDEAD_BEEF; step();
    checks++; if (r_o !== 1'b1 || d_o !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL pass_req r_o=%b d_o=%h want 1/deadbeef", r_o, d_o); end
    a_o = 1; step();
    checks++; if ({a_i, actl_i, r_o} !== 3'b110) begin errors++;
      $display("FAIL pass_ack a_i,actl_i,r_o=%b want 110", {a_i, actl_i, r_o}); end
    ctl_a = 0; r_i = 0; a_o = 0; step();
    checks++; if ({a_i, actl_i} !== 2'b00) begin errors++;
      $display("FAIL pass_rtz a_i,actl_i=%b want 00", {a_i, actl_i}); end
  endtask

  task automatic test_inject();
    do_reset();
    ctl_b = 1; r_i = 1; d_i = 32'hAAAA_5555; step();
    checks++; if (r_o !== 1'b1 || d_o !== 32'd5 || a_i !== 1'b0) begin errors++;
      $display("FAIL inject_req r_o=%b d_o=%h a_i=%b want 1/5/0", r_o, d_o, a_i); end
    a_o = 1; step();
    checks++; if ({a_i, actl_i, r_o} !== 3'b010) begin errors++;
      $display("FAIL inject_ack a_i,actl_i,r_o=%b want 010", {a_i, actl_i, r_o}); end
    ctl_b = 0; a_o = 0; step();
    checks++; if ({a_i, actl_i, r_o} !== 3'b000) begin errors++;
      $display("FAIL inject_rtz a_i,actl_i,r_o=%b want 000", {a_i, actl_i, r_o}); end
    ctl_a = 1; d_i = 32'h0000_1234; step();
    checks++; if (r_o !== 1'b1 || d_o !== 32'h1234) begin errors++;
      $display("FAIL inject_then_pass d_o=%h r_o=%b want 1234/1", d_o, r_o); end
    a_o = 1; step();
    checks++; if (a_i !== 1'b1) begin errors++; $display("FAIL inject_then_pass_ack a_i=%b want 1", a_i); end
    ctl_a = 0; r_i = 0; a_o = 0; step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ctl_b = 1; step();
      exp = CNT ? 32'd5 + 32'(i) : 32'd5;
      checks++; if (r_o !== 1'b1 || d_o !== exp) begin errors++;
        $display("FAIL b2b_token%0d d_o=%h r_o=%b want %h/1", i, d_o, r_o, exp); end
      a_o = 1; step();
      ctl_b = 0; a_o = 0; step();
    end
    for (int i = 0; i < 2; i++) begin
      w_ctl_b = 1; step();
      exp = (CNT && i == 1) ? 32'h0 : 32'hFFFF_FFFF;
      checks++; if (w_r_o !== 1'b1 || w_d_o !== exp) begin errors++;
        $display("FAIL wrap_token%0d d_o=%h r_o=%b want %h/1", i, w_d_o, w_r_o, exp); end
      w_a_o = 1; step();
      w_ctl_b = 0; w_a_o = 0; step();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    ctl_a = 1; ctl_b = 1; r_i = 1; d_i = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (r_o !== 1'b0 || ctl_err !== 1'b1) begin errors++;
        $display("FAIL illegal_cycle%0d r_o=%b ctl_err=%b want 0/1", i, r_o, ctl_err); end
    end
    ctl_a = 0; ctl_b = 0; r_i = 0; a_o = 1; step(); step();
    checks++; if (ctl_err !== 1'b1 || r_o !== 1'b0 || actl_i !== 1'b0) begin errors++;
      $display("FAIL illegal_sticky ctl_err=%b r_o=%b actl_i=%b want 1/0/0", ctl_err, r_o, actl_i); end
    a_o = 0;
  endtask

  task automatic test_slow();
    logic [31:0] d;
    do_reset();
    d = $urandom;
    ctl_a = 1; r_i = 1; d_i = d; step();
    d_i = ~d;
    for (int i = 0; i < 10; i++) begin
      checks++; if (r_o !== 1'b1 || d_o !== d) begin errors++;
        $display("FAIL slow_req_hold%0d r_o=%b d_o=%h want 1/%h", i, r_o, d_o, d); end
      step();
    end
    a_o = 1; step();
    checks++; if ({a_i, actl_i, r_o} !== 3'b110 || d_o !== d) begin errors++;
      $display("FAIL slow_ack a_i,actl_i,r_o=%b d_o=%h want 110/%h", {a_i, actl_i, r_o}, d_o, d); end
    a_o = 0; r_i = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({a_i, actl_i} !== 2'b11) begin errors++;
        $display("FAIL slow_rtz_hold%0d a_i,actl_i=%b want 11", i, {a_i, actl_i}); end
    end
    ctl_a = 0; step();
    checks++; if ({a_i, actl_i, r_o} !== 3'b000) begin errors++;
      $display("FAIL slow_release a_i,actl_i,r_o=%b want 000", {a_i, actl_i, r_o}); end
  endtask

  task automatic test_random();
    logic [31:0] inj, exp;
    bit          path_b;
    int          k;
    do_reset();
    inj = 32'd5;
    for (int t = 0; t < 40; t++) begin
      path_b = 1'($urandom_range(0, 1));
      exp = path_b ? inj : $urandom;
      if (path_b) begin ctl_b = 1; r_i = 1'($urandom_range(0, 1)); d_i = $urandom; end
      else begin ctl_a = 1; r_i = 1; d_i = exp; end
      k = 0;
      do begin step(); k++; end while (r_o !== 1'b1 && k < 6);
      checks++; if (r_o !== 1'b1 || d_o !== exp) begin errors++;
        $display("FAIL rand_req%0d r_o=%b d_o=%h want 1/%h", t, r_o, d_o, exp); end
      d_i = $urandom;
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        step();
        checks++; if (d_o !== exp || a_i !== 1'b0) begin errors++;
          $display("FAIL rand_hold%0d d_o=%h a_i=%b want %h/0", t, d_o, a_i, exp); end
      end
      a_o = 1; step();
      checks++; if (actl_i !== 1'b1 || a_i !== !path_b || r_o !== 1'b0) begin errors++;
        $display("FAIL rand_ack%0d actl_i=%b a_i=%b r_o=%b want 1/%b/0", t, actl_i, a_i, r_o, !path_b); end
      a_o = 0;
      for (int w = $urandom_range(0, 2); w > 0; w--) step();
      ctl_a = 0; ctl_b = 0;
      if (!path_b) r_i = 0;
      k = 0;
      do begin step(); k++; end while (actl_i !== 1'b0 && k < 6);
      checks++; if (actl_i !== 1'b0 || a_i !== 1'b0) begin errors++;
        $display("FAIL rand_rtz%0d actl_i=%b a_i=%b want 0/0", t, actl_i, a_i); end
      if (path_b && CNT) inj = inj + 32'd1;
    end
    clear_inputs(); step();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_inject();
    test_back_to_back();
    test_illegal();
    test_slow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
